ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, or 0xF4 enable. It sits beside the PS/2 keyboard receiver on the same ps2_clk/ps2_data pins and drives them open-drain through output-enable signals. The receiver must ignore the bus while tx_busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds ps2_clk low before requesting to send (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between device clock falling edges, and for the final bus-idle wait (20 ms at 50 MHz).

Ports:
clk  in  1  system clock
clr  in  1  reset, synchronous, active-high
tx_data  in  8  command byte; sampled when tx_start is accepted
tx_start  in  1  single-cycle request to send tx_data
tx_busy  out  1  high from acceptance until return to IDLE
tx_done  out  1  one-cycle pulse: byte sent and acknowledged
tx_err  out  1  one-cycle pulse: no ack, or timeout
ps2_clk_in  in  1  raw PS/2 clock pin level
ps2_data_in  in  1  raw PS/2 data pin level
ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release
ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release

Behaviour:
- Reset: while clr=1 at a clk edge, state=IDLE and all counters clear. tx_busy, tx_done, tx_err, ps2_clk_oe and ps2_data_oe are all 0. This applies mid-transfer too: both lines are released on the first clk edge with clr=1.
- Input conditioning:
  - ps2_clk_in and ps2_data_in pass through a 2-FF synchronizer.
  - ps2_clk additionally uses a 3-sample history. A falling edge ("fe") is the pattern 1,1,0 on the synchronized samples.
  - All protocol decisions use the synchronized values only.
- Shift register: {stop=1, parity, tx_data[7:0]} is latched on acceptance. parity = ~^tx_data (odd parity).
- tx_start handling: accepted only in IDLE. Ignored while tx_busy=1. tx_busy rises the cycle after acceptance.
- States:
  - IDLE: clk_oe=0, data_oe=0. tx_start goes to INHIBIT.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1 and data_oe=1 (start bit) for 1 cycle, then START.
  - START: clk_oe=0, data_oe=1; bit counter=0.
    - On each fe: drive data_oe = ~shift[0], shift right, increment count.
    - Counts 1..8 are the data bits (LSB first), count 9 is parity, count 10 is stop (data released).
    - After count 10, go to ACK.
  - ACK: on the next fe, sample data_in. 0 goes to WAIT_IDLE; 1 goes to ERR.
  - WAIT_IDLE: wait until synchronized clk=1 and data=1 simultaneously, then DONE.
  - DONE: tx_done=1 for 1 cycle, then IDLE.
  - ERR: tx_err=1 for 1 cycle, both oe=0, then IDLE.
- Timing of data_oe: changes exactly 1 clk after the cycle fe is detected, i.e. while the device clock is low. Setup to the device's rising-edge sample is therefore guaranteed.
- Timeout:
  - A counter runs in START, ACK and WAIT_IDLE. It clears on every fe and on each state entry.
  - Reaching TIMEOUT_CYCLES goes to ERR, releasing both lines in the same transition.
- Mutual exclusion: tx_done and tx_err never assert in the same cycle. tx_busy=0 in the cycle after DONE or ERR.
- ps2_clk_oe is never 1 outside INHIBIT and REQ. ps2_data_oe is never 1 in IDLE, ACK, WAIT_IDLE or ERR.
- Counter widths: sized by $clog2 of the respective parameter. The bit counter is 4 bits.

Test Plan:
- Reset mid-transfer: assert clr at device bit 4 → both oe=0 and tx_busy=0 next cycle. A subsequent tx_start for 0xFF works normally.
- Send 0xED with a behavioural device model (clock period ~80 us, ack asserted):
  - ps2_clk_oe high for exactly 5000 cycles, then REQ.
  - Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - tx_done pulses once; tx_busy is high throughout.
- Send 0x01 → device sees parity=0. Send 0x00 → parity=1. Both followed by tx_done.
- Device model withholds ack (data stays 1 at the 11th fe) → tx_err pulses once, no tx_done, both lines released.
- Device never clocks after REQ → tx_err exactly TIMEOUT_CYCLES (+ sync latency) after START entry. Use overrides INHIBIT_CYCLES=10 and TIMEOUT_CYCLES=200 for speed.
- tx_start pulsed repeatedly while busy, including in the DONE cycle → ignored. Only the first byte is sent, with no corrupted shift data.
- Glitch: a 1-cycle low spike on ps2_clk_in → no fe counted, because the 3-sample filter rejects it, and the bit order is unchanged.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a PS/2 host transmitter and the logic that
// issues commands to it.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_start,
        input  tx_busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts out start/data/parity/stop on device clock falling edges and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         clr,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, START, ACK, WAIT_IDLE, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         clk_sync_q, data_sync_q;
    logic [1:0]         clk_hist_q;
    logic               clk_s, data_s, fe, timeout;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [8:0]         shift_q, shift_d;
    logic               data_oe_q, data_oe_d;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    // Two high samples must precede the low one, so a low spike right after a
    // rising edge never counts as a falling edge.
    assign fe      = (clk_hist_q == 2'b11) && !clk_s;
    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the same
        // pre-edge values; blocking assignments would make the order matter.
        if (clr) begin
            state_q     <= IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_hist_q  <= '1;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '1;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_hist_q  <= {clk_hist_q[0], clk_s};
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_oe_q   <= data_oe_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed
        // branch would otherwise infer a latch.
        state_d   = state_q;
        inh_cnt_d = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (tx.tx_start) begin
                    shift_d = {1'b1, ~^tx.tx_data, tx.tx_data};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = REQ;
                else inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
            REQ: state_d = START;
            START: begin
                if (fe) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) state_d = ACK;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            ACK: begin
                if (fe) state_d = data_s ? ERR : WAIT_IDLE;
                else if (timeout) state_d = ERR;
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) state_d = DONE;
                else if (timeout) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The start bit goes out with REQ; every state that must leave data
        // released forces it off on the transition into that state.
        if (state_d == REQ) data_oe_d = 1'b1;
        else if (state_d inside {IDLE, INHIBIT, ACK, WAIT_IDLE, DONE, ERR}) data_oe_d = 1'b0;

        to_cnt_d = '0;
        if ((state_q inside {START, ACK, WAIT_IDLE}) && (state_d == state_q) && !fe)
            to_cnt_d = to_cnt_q + TO_W'(1);
    end

    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2_data_oe = data_oe_q;
    assign tx.tx_busy  = (state_q != IDLE);
    assign tx.tx_done  = (state_q == DONE);
    assign tx.tx_err   = (state_q == ERR);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host and compares them with frames built directly from the byte.
module tb_ps2_host_tx;
    localparam int INH  = 5000;
    localparam int TO   = 200;
    localparam int HALF = 20;

    typedef enum int {DEV_ACK, DEV_NACK, DEV_SILENT} dev_mode_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    int   dev_idx = -1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    ps2_host_tx_if bus_if ();

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk         (clk),
        .clr         (clr),
        .tx          (bus_if),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wire order: frame[i] is the i-th bit the device samples.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    int cyc = 0, done_cnt = 0, err_cnt = 0, inv_bad = 0;
    int inh_run = 0, last_inh = 0, req_run = 0, last_req = 0;
    int start_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        prev_clk_oe <= ps2_clk_oe;
        if (!clr) begin
            if (bus_if.tx_done) done_cnt <= done_cnt + 1;
            if (bus_if.tx_err)  err_cnt  <= err_cnt + 1;
            if ((bus_if.tx_done && bus_if.tx_err) ||
                (!bus_if.tx_busy && (ps2_clk_oe || ps2_data_oe)))
                inv_bad <= inv_bad + 1;
            if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
            else begin
                inh_run <= 0;
                if (inh_run != 0) last_inh <= inh_run;
            end
            if (ps2_clk_oe && ps2_data_oe) req_run <= req_run + 1;
            else begin
                req_run <= 0;
                if (req_run != 0) last_req <= req_run;
            end
            if (prev_clk_oe && !ps2_clk_oe) start_cyc <= cyc;
            if (bus_if.tx_err) err_cyc <= cyc;
        end
    end

    task automatic device(input bit ack, input int glitch, output logic [10:0] frame, output bit seen);
        int n;
        logic [10:0] f;
        f = '1;
        seen = 1'b0;
        dev_idx = -1;
        n = 0;
        while (!(ps2_clk_in && !ps2_data_in) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n < 20000) begin
            seen = 1'b1;
            for (int i = 0; i < 11; i++) begin
                dev_idx = i;
                repeat (HALF) @(negedge clk);
                f[i] = ps2_data_in;
                if (i == 10 && ack) begin
                    dev_data = 1'b0;
                    repeat (4) @(negedge clk);
                end
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b1;
                if (i == glitch) begin
                    @(negedge clk);
                    dev_clk = 1'b0;
                    @(negedge clk);
                    dev_clk = 1'b1;
                end
            end
            repeat (4) @(negedge clk);
            dev_data = 1'b1;
        end
        frame = f;
    endtask

    task automatic host_send(input logic [7:0] b, input bit spam, output int busy_lo, output bit fin);
        @(negedge clk);
        bus_if.tx_data  = b;
        bus_if.tx_start = 1'b1;
        @(negedge clk);
        bus_if.tx_start = 1'b0;
        busy_lo = 0;
        fin = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (!bus_if.tx_busy) busy_lo++;
            if (bus_if.tx_done || bus_if.tx_err) begin
                fin = 1'b1;
                if (spam) begin
                    bus_if.tx_data  = 8'h33;
                    bus_if.tx_start = 1'b1;
                    @(negedge clk);
                end
                break;
            end
            if (spam) begin
                bus_if.tx_start = (n % 500 == 7);
                bus_if.tx_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        bus_if.tx_start = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] b, input dev_mode_t mode,
                        input int glitch, input bit spam);
        logic [10:0] got;
        bit seen, fin;
        int busy_lo, d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        got = '0;
        seen = 1'b0;
        fork
            host_send(b, spam, busy_lo, fin);
            if (mode != DEV_SILENT) device(mode == DEV_ACK, glitch, got, seen);
        join
        n = 0;
        while (bus_if.tx_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check({tag, " finished"}, fin, 1);
        check({tag, " busy held"}, busy_lo, 0);
        check({tag, " inhibit len"}, last_inh, INH);
        check({tag, " req len"}, last_req, 1);
        check({tag, " done pulses"}, done_cnt - d0, (mode == DEV_ACK) ? 1 : 0);
        check({tag, " err pulses"}, err_cnt - e0, (mode == DEV_ACK) ? 0 : 1);
        check({tag, " idle+released"}, {bus_if.tx_busy, ps2_clk_oe, ps2_data_oe}, 0);
        if (mode == DEV_SILENT) begin
            check({tag, " timeout latency"}, err_cyc - start_cyc, TO);
        end else begin
            check({tag, " req seen"}, seen, 1);
            check({tag, " frame"}, got, model_frame(b));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [10:0] got;
        bit seen;
        int n;
        bus_if.tx_data  = 8'h00;
        bus_if.tx_start = 1'b0;
        repeat (4) @(negedge clk);
        check("reset outputs",
              {bus_if.tx_busy, bus_if.tx_done, bus_if.tx_err, ps2_clk_oe, ps2_data_oe}, 0);
        clr = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame, while data bit 3 is on the wire.
        bus_if.tx_data  = 8'hA5;
        bus_if.tx_start = 1'b1;
        @(negedge clk);
        bus_if.tx_start = 1'b0;
        fork
            device(1'b1, -1, got, seen);
            begin
                n = 0;
                while (dev_idx < 4 && n < 20000) begin
                    @(negedge clk);
                    n++;
                end
                check("mid reset reached bit 4", n < 20000, 1);
                clr = 1'b1;
                @(negedge clk);
                check("mid reset released", {bus_if.tx_busy, ps2_clk_oe, ps2_data_oe}, 0);
                clr = 1'b0;
            end
        join
        repeat (10) @(negedge clk);

        xfer("FF after reset", 8'hFF, DEV_ACK, -1, 1'b0);
        xfer("ED", 8'hED, DEV_ACK, -1, 1'b0);
        xfer("01", 8'h01, DEV_ACK, -1, 1'b0);
        xfer("00", 8'h00, DEV_ACK, -1, 1'b0);
        xfer("nack F4", 8'hF4, DEV_NACK, -1, 1'b0);
        xfer("silent device", 8'h5C, DEV_SILENT, -1, 1'b0);
        xfer("start while busy", 8'hC6, DEV_ACK, -1, 1'b1);
        xfer("glitch ED", 8'hED, DEV_ACK, 4, 1'b0);
        for (int k = 0; k < 2; k++)
            xfer($sformatf("rand%0d", k), 8'($urandom), DEV_ACK, int'($urandom_range(0, 9)), 1'b0);

        check("done/err exclusive, oe only while busy", inv_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
